// File: rtl/counter_pkg.sv
// Shared mode encoding for the counter family.
package counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP      = 2'b00;
  localparam mode_t MODE_DN      = 2'b01;
  localparam mode_t MODE_DN_STEP = 2'b10;
  localparam mode_t MODE_LOAD    = 2'b11;

endpackage

// File: rtl/counter_param_next.sv
// Combinational next-count logic: next value, overflow/borrow flag and terminal count.
module counter_param_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned STEP     = 3,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             enable,
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] next_q,
  output logic             ovf_brw,
  output logic             tc
);

  localparam logic [WIDTH:0]   StepExt = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   OneExt  = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] QMax    = '1;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] clamp;

  // One extra bit: carry-out on increment, sign (borrow) on decrement.
  always_comb begin
    sum     = {1'b0, q};
    clamp   = '0;
    ovf_brw = 1'b0;
    unique case (mode)
      MODE_UP: begin
        sum     = {1'b0, q} + OneExt;
        ovf_brw = sum[WIDTH];
        clamp   = QMax;
      end
      MODE_DN: begin
        sum     = {1'b0, q} - OneExt;
        ovf_brw = sum[WIDTH];
      end
      MODE_DN_STEP: begin
        sum     = {1'b0, q} - StepExt;
        ovf_brw = sum[WIDTH];
      end
      MODE_LOAD: begin
        sum = {1'b0, d};
      end
    endcase
    next_q = (SATURATE && ovf_brw) ? clamp : sum[WIDTH-1:0];
    tc     = enable & ovf_brw;
  end

endmodule

// File: rtl/counter_param.sv
// Parametrised mode counter: up, down, down-by-STEP and load, with optional saturation.
module counter_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned STEP     = 3,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             ENABLE,
  input  mode_t            MODE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             LOAD,
  output logic             TC
);

  logic [WIDTH-1:0] q_q;
  logic             rco_q;
  logic             load_q;
  logic [WIDTH-1:0] next_q;
  logic             ovf_brw;

  counter_param_next #(
    .WIDTH    (WIDTH),
    .STEP     (STEP),
    .SATURATE (SATURATE)
  ) u_next (
    .enable  (ENABLE),
    .q       (q_q),
    .mode    (MODE),
    .d       (D),
    .next_q  (next_q),
    .ovf_brw (ovf_brw),
    .tc      (TC)
  );

  // Reset dominates enable; a disabled edge holds Q and clears both pulses.
  always_ff @(posedge clk) begin
    if (RESET) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else if (!ENABLE) begin
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      q_q    <= next_q;
      rco_q  <= ovf_brw;
      load_q <= (MODE == MODE_LOAD);
    end
  end

  assign Q    = q_q;
  assign RCO  = rco_q;
  assign LOAD = load_q;

endmodule

// File: tb/tb_counter_param.sv
// Self-checking bench: directed vector table, saturation and cascade sequences, random vs model.
module tb_counter_param;
  import counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit wrap instance
  logic       a_rst, a_en;
  mode_t      a_mode;
  logic [3:0] a_d, a_q;
  logic       a_rco, a_load, a_tc;
  // 8-bit saturating instance
  logic       b_rst, b_en;
  mode_t      b_mode;
  logic [7:0] b_d, b_q;
  logic       b_rco, b_load, b_tc;
  // cascaded pair
  logic       c_rst;
  mode_t      c_mode;
  logic [3:0] c_d, lo_q, hi_q;
  logic       lo_rco, lo_load, lo_tc, hi_rco, hi_load, hi_tc;

  counter_param #(.WIDTH(4), .STEP(3), .SATURATE(1'b0)) u_a (
    .clk(clk), .RESET(a_rst), .ENABLE(a_en), .MODE(a_mode), .D(a_d),
    .Q(a_q), .RCO(a_rco), .LOAD(a_load), .TC(a_tc));

  counter_param #(.WIDTH(8), .STEP(3), .SATURATE(1'b1)) u_b (
    .clk(clk), .RESET(b_rst), .ENABLE(b_en), .MODE(b_mode), .D(b_d),
    .Q(b_q), .RCO(b_rco), .LOAD(b_load), .TC(b_tc));

  counter_param #(.WIDTH(4), .STEP(3), .SATURATE(1'b0)) u_lo (
    .clk(clk), .RESET(c_rst), .ENABLE(1'b1), .MODE(c_mode), .D(c_d),
    .Q(lo_q), .RCO(lo_rco), .LOAD(lo_load), .TC(lo_tc));

  counter_param #(.WIDTH(4), .STEP(3), .SATURATE(1'b0)) u_hi (
    .clk(clk), .RESET(c_rst), .ENABLE(lo_tc), .MODE(c_mode), .D(c_d),
    .Q(hi_q), .RCO(hi_rco), .LOAD(hi_load), .TC(hi_tc));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] d;
    logic       tc;
    logic [3:0] q;
    logic       rco;
    logic       load;
  } vec_t;

  function automatic vec_t mk(logic rst, logic en, logic [1:0] mode, logic [3:0] d,
                              logic tc, logic [3:0] q, logic rco, logic load);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.d = d;
    v.tc = tc; v.q = q; v.rco = rco; v.load = load;
    return v;
  endfunction

  // Reference: plain integer arithmetic on the counting rules.
  typedef struct {
    int q;
    bit rco;
    bit load;
    bit tc;
  } res_t;

  function automatic res_t ref_step(int q, int mode, int d, bit en, bit rst,
                                    int w, int step, bit sat);
    res_t r;
    int   m;
    int   v;
    m      = 1 << w;
    r.tc   = en && (mode != 3) &&
             ((mode == 0 && q == m - 1) || (mode == 1 && q == 0) || (mode == 2 && q < step));
    r.q    = q;
    r.rco  = 1'b0;
    r.load = 1'b0;
    if (rst) begin
      r.q = 0;
    end else if (en) begin
      if (mode == 3) begin
        r.q    = d;
        r.load = 1'b1;
      end else begin
        v = (mode == 0) ? q + 1 : (mode == 1) ? q - 1 : q - step;
        if (v < 0 || v >= m) begin
          r.rco = 1'b1;
          r.q   = sat ? ((v < 0) ? 0 : m - 1) : (((v % m) + m) % m);
        end else begin
          r.q = v;
        end
      end
    end
    return r;
  endfunction

  task automatic a_cyc(input vec_t v, input int idx, input bit chk_tc);
    a_rst = v.rst; a_en = v.en; a_mode = v.mode; a_d = v.d;
    #1;
    if (chk_tc) chk($sformatf("vec%0d tc", idx), a_tc, v.tc);
    @(posedge clk); #1;
    chk($sformatf("vec%0d q", idx), a_q, v.q);
    chk($sformatf("vec%0d rco", idx), a_rco, v.rco);
    chk($sformatf("vec%0d load", idx), a_load, v.load);
  endtask

  task automatic b_cyc(input string name, input logic rst, input logic en, input mode_t mode,
                       input logic [7:0] d, input logic tc, input logic [7:0] q,
                       input logic rco, input logic load);
    b_rst = rst; b_en = en; b_mode = mode; b_d = d;
    #1;
    chk({name, " tc"}, b_tc, tc);
    @(posedge clk); #1;
    chk({name, " q"}, b_q, q);
    chk({name, " rco"}, b_rco, rco);
    chk({name, " load"}, b_load, load);
  endtask

  vec_t vecs[$];
  res_t ra, rb;
  int   ma, mb;

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_mode = MODE_UP; a_d = '0;
    b_rst = 1'b1; b_en = 1'b0; b_mode = MODE_UP; b_d = '0;
    c_rst = 1'b1; c_mode = MODE_UP; c_d = '0;

    // rst en mode d | tc q rco load
    vecs.push_back(mk(1, 1, 2'b00, 4'h9, 0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 4'h9, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 2'b11, 4'hE, 0, 4'hE, 0, 1));
    vecs.push_back(mk(0, 1, 2'b00, 4'h0, 0, 4'hF, 0, 0));
    vecs.push_back(mk(0, 1, 2'b00, 4'h0, 1, 4'h0, 1, 0));
    vecs.push_back(mk(0, 1, 2'b00, 4'h0, 0, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 2'b11, 4'h4, 0, 4'h4, 0, 1));
    vecs.push_back(mk(0, 1, 2'b10, 4'h0, 0, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 2'b10, 4'h0, 1, 4'hE, 1, 0));
    vecs.push_back(mk(0, 1, 2'b10, 4'h0, 0, 4'hB, 0, 0));
    vecs.push_back(mk(0, 1, 2'b11, 4'h5, 0, 4'h5, 0, 1));
    vecs.push_back(mk(0, 0, 2'b01, 4'h3, 0, 4'h5, 0, 0));
    vecs.push_back(mk(0, 0, 2'b01, 4'h3, 0, 4'h5, 0, 0));
    vecs.push_back(mk(0, 0, 2'b01, 4'h3, 0, 4'h5, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'h0, 0, 4'h4, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'h0, 0, 4'h3, 0, 0));
    vecs.push_back(mk(0, 1, 2'b00, 4'h0, 0, 4'h4, 0, 0));
    vecs.push_back(mk(1, 1, 2'b01, 4'h0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'h0, 1, 4'hF, 1, 0));
    vecs.push_back(mk(1, 1, 2'b11, 4'hA, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b11, 4'h7, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 2'b10, 4'h0, 1, 4'hD, 1, 0));

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) a_cyc(vecs[i], i, i != 0);

    // Saturating 8-bit: pinned counter keeps RCO high while enabled.
    b_cyc("sat rst",  1, 1, MODE_UP,      8'h00, 0, 8'h00, 0, 0);
    b_cyc("sat ld",   0, 1, MODE_LOAD,    8'hFE, 0, 8'hFE, 0, 1);
    b_cyc("sat up0",  0, 1, MODE_UP,      8'h00, 0, 8'hFF, 0, 0);
    b_cyc("sat up1",  0, 1, MODE_UP,      8'h00, 1, 8'hFF, 1, 0);
    b_cyc("sat up2",  0, 1, MODE_UP,      8'h00, 1, 8'hFF, 1, 0);
    b_cyc("sat dn",   0, 1, MODE_DN,      8'h00, 0, 8'hFE, 0, 0);
    b_cyc("sat ld1",  0, 1, MODE_LOAD,    8'h01, 0, 8'h01, 0, 1);
    b_cyc("sat stp",  0, 1, MODE_DN_STEP, 8'h00, 1, 8'h00, 1, 0);
    b_cyc("sat dn0",  0, 1, MODE_DN,      8'h00, 1, 8'h00, 1, 0);
    b_cyc("sat hold", 0, 0, MODE_DN,      8'h00, 0, 8'h00, 0, 0);

    // Cascade: high stage advances only on the low stage's wrap edge.
    c_rst = 1'b1;
    @(posedge clk); #1;
    chk("casc rst", {hi_q, lo_q}, 8'h00);
    c_rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      #1;
      chk($sformatf("casc tc%0d", n), lo_tc, ((n - 1) % 16) == 15);
      @(posedge clk); #1;
      chk($sformatf("casc q%0d", n), {hi_q, lo_q}, n % 256);
    end

    // Random stimulus against the integer model.
    ma = 0; mb = 0;
    a_rst = 1'b1; b_rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      a_rst  = ($urandom_range(0, 31) == 0);
      a_en   = ($urandom_range(0, 3) != 0);
      a_mode = mode_t'($urandom_range(0, 3));
      a_d    = 4'($urandom_range(0, 15));
      b_rst  = ($urandom_range(0, 31) == 0);
      b_en   = ($urandom_range(0, 3) != 0);
      b_mode = mode_t'($urandom_range(0, 3));
      b_d    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255))
                                           : 8'($urandom_range(0, 5));
      ra = ref_step(ma, int'(a_mode), int'(a_d), a_en, a_rst, 4, 3, 1'b0);
      rb = ref_step(mb, int'(b_mode), int'(b_d), b_en, b_rst, 8, 3, 1'b1);
      #1;
      chk($sformatf("rnd%0d a tc", i), a_tc, ra.tc);
      chk($sformatf("rnd%0d b tc", i), b_tc, rb.tc);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d a q", i), a_q, ra.q);
      chk($sformatf("rnd%0d a rco", i), a_rco, ra.rco);
      chk($sformatf("rnd%0d a load", i), a_load, ra.load);
      chk($sformatf("rnd%0d b q", i), b_q, rb.q);
      chk($sformatf("rnd%0d b rco", i), b_rco, rb.rco);
      chk($sformatf("rnd%0d b load", i), b_load, rb.load);
      chk($sformatf("rnd%0d a excl", i), a_rco & a_load, 1'b0);
      ma = ra.q;
      mb = rb.q;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_param.md
Name: counter_param

Overview:
Parametrised successor to the 4-bit mode counter.
- Generalised width and down-step size.
- Adds optional saturation instead of wrap.
- Adds a combinational terminal-count output for cascading.
- Sits in the same verification top as the 4-bit counter. It is instantiated behaviourally, synthesised, and compared against its synthesised netlist by the counters testbench.

Parameters:
WIDTH, 4, counter width in bits (>=2)
STEP, 3, decrement size for MODE=10 (1 <= STEP <= 2^WIDTH-1)
SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at 0 / 2^WIDTH-1

Ports:
clk  input  1  single clock, all state on rising edge
RESET  input  1  synchronous, active-high reset
ENABLE  input  1  count/load enable; 0 = hold
MODE  input  2  00 up by 1, 01 down by 1, 10 down by STEP, 11 parallel load
D  input  WIDTH  load value for MODE=11
Q  output  WIDTH  registered count
RCO  output  1  registered ripple-carry/borrow flag, one-cycle pulse
LOAD  output  1  registered, 1 for the cycle following a load
TC  output  1  combinational: next enabled edge will wrap, borrow or clamp

Behaviour:
- One clock (clk). Reset is synchronous and active-high (RESET). RESET has priority over every other input.
- Reset values: Q=0, RCO=0, LOAD=0. TC follows its equation from Q=0 (e.g. TC=1 if MODE=01, ENABLE=1).
- Latency is 1 cycle. MODE, D and ENABLE are sampled at each rising edge. A mode change takes effect on that same edge, with no pipeline.
- ENABLE=0: Q holds; RCO<=0; LOAD<=0.
- MODE=00: Q<=Q+1. Overflow when Q==2^WIDTH-1.
- MODE=01: Q<=Q-1. Borrow when Q==0.
- MODE=10: Q<=Q-STEP. Borrow when Q<STEP. Arithmetic is done in WIDTH+1 bits.
  - Wrap result = (Q-STEP) mod 2^WIDTH, e.g. WIDTH=4, STEP=3: 1 -> E.
- MODE=11: Q<=D; LOAD<=1; RCO<=0.
- RCO<=1 on the edge where an enabled MODE 00/01/10 operation overflows or borrows; otherwise RCO<=0.
- SATURATE=0: Q wraps as above.
- SATURATE=1: on overflow Q<=2^WIDTH-1; on borrow Q<=0. RCO is still 1 on each such edge, so a pinned counter gives a continuous RCO while enabled.
- TC = ENABLE & (MODE!=11) & overflow/borrow condition for the current MODE and Q. It is purely combinational and feeds the next stage's ENABLE for synchronous cascading.
- LOAD and RCO are never both 1.
- Reset asserted in the same cycle as MODE=11: reset wins (Q=0, LOAD=0).
- Reset released mid-sequence: counting resumes from 0 on the first edge with RESET=0.
- WIDTH=4, STEP=3, SATURATE=0 must be cycle-identical to the existing 4-bit counter on Q, RCO and LOAD.

Decomposition:
- Shared package counter_pkg:
  - mode constants MODE_UP=2'b00, MODE_DN=2'b01, MODE_DN_STEP=2'b10, MODE_LOAD=2'b11
  - a typedef for the 2-bit mode.
- One sub-module, counter_param_next. It is combinational and computes next_q, ovf_brw and tc from Q, MODE, D and the parameters.
- The top holds the Q/RCO/LOAD registers and the reset/enable priority.

Test Plan:
1. Reset: RESET=1 for 2 cycles with ENABLE=1, MODE=00, D=4'h9 -> Q=0, RCO=0, LOAD=0 on both edges.
2. Load then up-wrap (WIDTH=4): MODE=11, D=E -> Q=E, LOAD=1 for one cycle. Then MODE=00 -> Q=F (TC=1 while Q=F), then Q=0 with RCO=1, then Q=1 with RCO=0.
3. Down by STEP: load 4, then MODE=10 -> Q=1 (RCO=0), then Q=E (RCO=1, TC=1 the cycle before), then Q=B (RCO=0).
4. Hold and mode switch: Q=5, ENABLE=0 for 3 cycles -> Q=5, RCO=0. Then ENABLE=1 with MODE=01 -> 4, 3. Switch to MODE=00 -> 4.
5. Saturation (WIDTH=8, SATURATE=1): load FE, MODE=00 -> FF (RCO=0), then FF (RCO=1), FF (RCO=1). Then MODE=01 -> FE (RCO=0).
6. Reset collision and cascade: RESET=1 with MODE=11, D=A -> Q=0, LOAD=0. Two WIDTH=4 instances with the low stage's TC driving the high stage's ENABLE, counting up from 00 -> high stage increments only on low-stage wrap: 0F then 10.
